// File: rtl/io_rs232_replay.sv
// Replays timestamped RS-232 line-state records from a USB OUT endpoint buffer.
// Each 3-byte record {state, delay_hi, delay_lo} is driven onto line_out after its delay.
module io_rs232_replay #(
    parameter logic [15:0] PRESCALE   = 16'd1,
    parameter logic [7:0]  IDLE_STATE = 8'hE0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [8:0]  buf_out_addr,
    input  logic [7:0]  buf_out_q,
    input  logic [9:0]  buf_out_len,
    input  logic        buf_out_hasdata,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack,
    input  logic        vend_req_act,
    input  logic [7:0]  vend_req_request,
    output logic [7:0]  line_out,
    output logic        busy,
    output logic [15:0] rec_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DATA, S_FETCH, S_DELAY, S_APPLY, S_ARM, S_ARM_WAIT
    } state_t;

    state_t      state, state_next;
    logic [1:0]  hasdata_sync;
    logic [2:0]  act_sync;
    logic [9:0]  len_q;
    logic [9:0]  ptr;
    logic [2:0]  fcnt;
    logic [7:0]  q_r;
    logic [7:0]  rec_state, rec_dhi, rec_dlo;
    logic [15:0] pcnt, dcnt;
    logic        aborting;

    logic hasdata_s, act_rise, start_evt, abort_evt, tick_last, more_records;

    assign hasdata_s    = hasdata_sync[1];
    assign act_rise     = act_sync[1] & ~act_sync[2];
    assign start_evt    = act_rise && (vend_req_request == 8'h02);
    assign abort_evt    = act_rise && (vend_req_request == 8'h03);
    assign tick_last    = (pcnt == PRESCALE - 16'd1);
    assign more_records = ({1'b0, ptr} + 11'd6) <= {1'b0, len_q};

    // Arm handshake: buf_out_arm is a one-cycle request that hands the buffer back;
    // buf_out_arm_ack may follow any number of cycles later and is waited for in ARM_WAIT.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start_evt) state_next = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (abort_evt)      state_next = S_IDLE;
                else if (hasdata_s) state_next = (buf_out_len >= 10'd3) ? S_FETCH : S_ARM;
            end
            S_FETCH: begin
                if (abort_evt)          state_next = S_ARM;
                else if (fcnt == 3'd6)  state_next = ({rec_dhi, rec_dlo} == 16'd0) ? S_APPLY : S_DELAY;
            end
            S_DELAY: begin
                if (abort_evt)                         state_next = S_ARM;
                else if (tick_last && dcnt == 16'd1)   state_next = S_APPLY;
            end
            S_APPLY: begin
                if (abort_evt)         state_next = S_ARM;
                else if (more_records) state_next = S_FETCH;
                else                   state_next = S_ARM;
            end
            S_ARM:       state_next = S_ARM_WAIT;
            S_ARM_WAIT: begin
                if (buf_out_arm_ack) state_next = (aborting || abort_evt) ? S_IDLE : S_WAIT_DATA;
            end
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            hasdata_sync <= 2'b00;
            act_sync     <= 3'b000;
            len_q        <= 10'd0;
            ptr          <= 10'd0;
            fcnt         <= 3'd0;
            q_r          <= 8'd0;
            rec_state    <= 8'd0;
            rec_dhi      <= 8'd0;
            rec_dlo      <= 8'd0;
            pcnt         <= 16'd0;
            dcnt         <= 16'd0;
            aborting     <= 1'b0;
            buf_out_addr <= 9'd0;
            buf_out_arm  <= 1'b0;
            line_out     <= IDLE_STATE;
            busy         <= 1'b0;
            rec_count    <= 16'd0;
        end else begin
            hasdata_sync <= {hasdata_sync[0], buf_out_hasdata};
            act_sync     <= {act_sync[1:0], vend_req_act};
            q_r          <= buf_out_q;
            state        <= state_next;
            busy         <= (state_next != S_IDLE);
            buf_out_arm  <= (state_next == S_ARM);

            if (state_next == S_IDLE)                   aborting <= 1'b0;
            else if (abort_evt && state != S_IDLE)      aborting <= 1'b1;

            if (start_evt && state == S_IDLE) rec_count <= 16'd0;

            case (state)
                S_WAIT_DATA: begin
                    if (hasdata_s && !abort_evt) begin
                        len_q <= buf_out_len;
                        ptr   <= 10'd0;
                    end
                end
                S_FETCH: begin
                    // Buffer data lags its address by two clocks, plus one input register stage.
                    fcnt <= fcnt + 3'd1;
                    case (fcnt)
                        3'd0:    buf_out_addr <= ptr[8:0] + 9'd1;
                        3'd1:    buf_out_addr <= ptr[8:0] + 9'd2;
                        3'd3:    rec_state    <= q_r;
                        3'd4:    rec_dhi      <= q_r;
                        3'd5:    rec_dlo      <= q_r;
                        default: ;
                    endcase
                end
                S_DELAY: begin
                    if (tick_last) begin
                        pcnt <= 16'd0;
                        dcnt <= dcnt - 16'd1;
                    end else begin
                        pcnt <= pcnt + 16'd1;
                    end
                end
                S_APPLY: begin
                    if (!abort_evt) begin
                        line_out  <= rec_state;
                        rec_count <= rec_count + 16'd1;
                        ptr       <= ptr + 10'd3;
                    end
                end
                default: ;
            endcase

            if (state_next == S_FETCH && state != S_FETCH) begin
                fcnt         <= 3'd0;
                buf_out_addr <= (state == S_APPLY) ? ptr[8:0] + 9'd3 : 9'd0;
            end
            if (state == S_FETCH && state_next == S_DELAY) begin
                pcnt <= 16'd0;
                dcnt <= {rec_dhi, rec_dlo};
            end
            if (abort_evt && state != S_IDLE) line_out <= IDLE_STATE;
        end
    end

endmodule

// File: tb/tb_io_rs232_replay.sv
// Directed bench for io_rs232_replay: one instance at PRESCALE=1, one at PRESCALE=4,
// a two-stage-latency buffer model and an automatic arm/ack endpoint responder.
module tb_io_rs232_replay;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  addr [2];
    logic [7:0]  q [2];
    logic [7:0]  q1 [2];
    logic [9:0]  len;
    logic        hasdata [2];
    logic        arm [2];
    logic        ack [2];
    logic        act [2];
    logic [7:0]  req;
    logic [7:0]  line [2];
    logic        busy [2];
    logic [15:0] cnt [2];
    logic [7:0]  mem [512];

    int sel, cyc, n_vec, n_err;
    int arm_cnt [2];
    int done_cnt [2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            q1[i] <= mem[addr[i]];
            q[i]  <= q1[i];
        end
    end

    io_rs232_replay #(.PRESCALE(16'd1), .IDLE_STATE(8'hE0)) dut (
        .clk(clk), .reset(rst), .buf_out_addr(addr[0]), .buf_out_q(q[0]),
        .buf_out_len(len), .buf_out_hasdata(hasdata[0]), .buf_out_arm(arm[0]),
        .buf_out_arm_ack(ack[0]), .vend_req_act(act[0]), .vend_req_request(req),
        .line_out(line[0]), .busy(busy[0]), .rec_count(cnt[0])
    );

    io_rs232_replay #(.PRESCALE(16'd4), .IDLE_STATE(8'hE0)) dut_p4 (
        .clk(clk), .reset(rst), .buf_out_addr(addr[1]), .buf_out_q(q[1]),
        .buf_out_len(len), .buf_out_hasdata(hasdata[1]), .buf_out_arm(arm[1]),
        .buf_out_arm_ack(ack[1]), .vend_req_act(act[1]), .vend_req_request(req),
        .line_out(line[1]), .busy(busy[1]), .rec_count(cnt[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Endpoint model: drops hasdata on arm, acks three clocks later.
    task automatic responder(input int i);
        forever begin
            @(posedge clk);
            #1;
            if (arm[i] === 1'b1) begin
                arm_cnt[i]++;
                hasdata[i] = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                ack[i] = 1'b1;
                @(posedge clk);
                #1;
                ack[i] = 1'b0;
                done_cnt[i]++;
            end
        end
    endtask

    task automatic send_req(input logic [7:0] code);
        req = code;
        act[sel] = 1'b1;
        repeat (4) step();
        act[sel] = 1'b0;
        repeat (4) step();
    endtask

    task automatic load_pkt(input logic [7:0] b0, b1, b2, b3, b4, b5, input logic [9:0] n);
        mem[0] = b0; mem[1] = b1; mem[2] = b2;
        mem[3] = b3; mem[4] = b4; mem[5] = b5;
        len = n;
        hasdata[sel] = 1'b1;
    endtask

    task automatic measure(input int budget, output int t_a1, output int t_ap);
        logic [7:0] prev;
        int n;
        prev = line[sel];
        t_a1 = -1000;
        t_ap = 0;
        n = 0;
        while (n < budget && t_ap == 0) begin
            step();
            n++;
            if (t_a1 < 0 && addr[sel] == 9'd1) t_a1 = cyc;
            if (line[sel] !== prev) t_ap = cyc;
        end
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt[sel] < target && n < 300) begin
            step();
            n++;
        end
        check_eq("arm_ack_done", done_cnt[sel], target);
        repeat (3) step();
    endtask

    task automatic wait_addr1(input string tag);
        int n;
        n = 0;
        while (addr[sel] !== 9'd1 && n < 60) begin
            step();
            n++;
        end
        check_eq(tag, addr[sel], 9'd1);
    endtask

    initial begin
        int t1, ta, k, n;
        int tch [2];
        logic [7:0] val [2];
        logic [7:0] prev;

        rst = 1'b1;
        req = 8'h00;
        len = 10'd0;
        sel = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            hasdata[i] = 1'b0;
            ack[i] = 1'b0;
            act[i] = 1'b0;
        end
        fork
            responder(0);
            responder(1);
        join_none

        repeat (3) step();
        check_eq("rst_line", line[0], 8'hE0);
        check_eq("rst_busy", busy[0], 1'b0);
        check_eq("rst_count", cnt[0], 16'd0);
        check_eq("rst_arm", arm[0], 1'b0);
        check_eq("rst_addr", addr[0], 9'd0);
        check_eq("rst_line_p4", line[1], 8'hE0);
        rst = 1'b0;
        repeat (2) step();

        // Single record, delay 10 ticks at PRESCALE=1.
        send_req(8'h02);
        check_eq("start_busy", busy[0], 1'b1);
        load_pkt(8'h55, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 10'd3);
        measure(200, t1, ta);
        check_eq("single_latency", ta - t1, 17);
        check_eq("single_line", line[0], 8'h55);
        check_eq("single_count", cnt[0], 16'd1);
        wait_done(1);
        check_eq("single_arms", arm_cnt[0], 1);
        check_eq("single_wait_busy", busy[0], 1'b1);
        check_eq("single_hold", line[0], 8'h55);

        // Two back-to-back zero-delay records.
        load_pkt(8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 10'd6);
        prev = line[0];
        k = 0; n = 0;
        tch[0] = 0; tch[1] = -100;
        val[0] = 8'h00; val[1] = 8'h00;
        while (k < 2 && n < 200) begin
            step();
            n++;
            if (line[0] !== prev) begin
                tch[k] = cyc;
                val[k] = line[0];
                prev = line[0];
                k++;
            end
        end
        check_eq("b2b_first", val[0], 8'h01);
        check_eq("b2b_second", val[1], 8'h02);
        check_eq("b2b_spacing", tch[1] - tch[0], 8);
        check_eq("b2b_count", cnt[0], 16'd3);
        wait_done(2);
        check_eq("b2b_arms", arm_cnt[0], 2);

        // Empty and short packets.
        load_pkt(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 10'd0);
        wait_done(3);
        check_eq("empty_line", line[0], 8'h02);
        check_eq("empty_count", cnt[0], 16'd3);
        check_eq("empty_arms", arm_cnt[0], 3);
        load_pkt(8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00, 10'd2);
        wait_done(4);
        check_eq("short_line", line[0], 8'h02);
        check_eq("short_count", cnt[0], 16'd3);
        check_eq("short_arms", arm_cnt[0], 4);

        // Asynchronous reset in the middle of a fetch.
        load_pkt(8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 10'd3);
        wait_addr1("rst_mid_fetch_reached");
        rst = 1'b1;
        #1;
        check_eq("arst_line", line[0], 8'hE0);
        check_eq("arst_busy", busy[0], 1'b0);
        check_eq("arst_count", cnt[0], 16'd0);
        check_eq("arst_arm", arm[0], 1'b0);
        hasdata[0] = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        check_eq("arst_no_arm", arm_cnt[0], 4);
        check_eq("arst_idle", busy[0], 1'b0);

        send_req(8'h02);
        load_pkt(8'h5A, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 10'd3);
        measure(200, t1, ta);
        check_eq("post_rst_latency", ta - t1, 9);
        check_eq("post_rst_line", line[0], 8'h5A);
        check_eq("post_rst_count", cnt[0], 16'd1);
        wait_done(5);
        check_eq("post_rst_arms", arm_cnt[0], 5);

        // Abort while a long delay is running.
        load_pkt(8'h77, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 10'd3);
        wait_addr1("abort_fetch_reached");
        repeat (15) step();
        check_eq("abort_pending_line", line[0], 8'h5A);
        req = 8'h03;
        act[0] = 1'b1;
        n = 0;
        while (line[0] !== 8'hE0 && n < 6) begin
            step();
            n++;
        end
        check_eq("abort_line", line[0], 8'hE0);
        check_eq("abort_latency_ok", (n <= 3), 1'b1);
        repeat (3) step();
        act[0] = 1'b0;
        wait_done(6);
        check_eq("abort_arms", arm_cnt[0], 6);
        check_eq("abort_idle", busy[0], 1'b0);
        check_eq("abort_count_kept", cnt[0], 16'd1);
        repeat (40) step();
        check_eq("abort_never_applied", line[0], 8'hE0);

        send_req(8'h03);
        check_eq("idle_abort_busy", busy[0], 1'b0);
        check_eq("idle_abort_arms", arm_cnt[0], 6);

        // PRESCALE=4 with two trailing bytes.
        sel = 1;
        send_req(8'h02);
        check_eq("p4_start_busy", busy[1], 1'b1);
        load_pkt(8'hAA, 8'h00, 8'h03, 8'h11, 8'h22, 8'h00, 10'd5);
        measure(200, t1, ta);
        check_eq("p4_latency", ta - t1, 19);
        check_eq("p4_line", line[1], 8'hAA);
        check_eq("p4_count", cnt[1], 16'd1);
        wait_done(1);
        repeat (20) step();
        check_eq("p4_trailing_line", line[1], 8'hAA);
        check_eq("p4_trailing_count", cnt[1], 16'd1);
        check_eq("p4_arms", arm_cnt[1], 1);
        check_eq("p4_wait_busy", busy[1], 1'b1);
        check_eq("p0_untouched", line[0], 8'hE0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/io_rs232_replay.md
Name: io_rs232_replay

Overview:
- Playback counterpart of the RS-232 capture path.
- Reads timestamped line-state records from a USB OUT endpoint buffer and drives them onto an 8-bit RS-232 output bundle. Each record's state is applied after its programmed delay.
- Started and stopped by vendor requests. Re-arms the endpoint after each packet has been consumed.

Parameters:
- PRESCALE, 16'd1, clk cycles per delay tick. Legal range 1..65535.
- IDLE_STATE, 8'hE0, value driven on line_out at reset, in idle and after abort.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- buf_out_addr  output  9  endpoint buffer read address
- buf_out_q  input  8  endpoint buffer read data; valid 2 clk after buf_out_addr changes
- buf_out_len  input  10  byte count of the current packet; valid while buf_out_hasdata=1
- buf_out_hasdata  input  1  packet available; treated as asynchronous and 2-FF synchronised internally
- buf_out_arm  output  1  one-cycle pulse that releases the buffer back to the endpoint
- buf_out_arm_ack  input  1  endpoint accepted the arm; same clock domain
- vend_req_act  input  1  vendor request strobe; 2-FF synchronised, rising edge detected
- vend_req_request  input  8  8'h02 = start, 8'h03 = abort
- line_out  output  8  {TXD,RTS,DTR,RXD,CTS,DSR,CD,RI}
- busy  output  1  high in every state except IDLE
- rec_count  output  16  records applied since the last start; wraps at 16'hFFFF -> 0

Behaviour:
- Reset values (asynchronous): line_out=IDLE_STATE, buf_out_addr=0, buf_out_arm=0, busy=0, rec_count=0, state=IDLE.
- Record format: 3 bytes, in order: state[7:0], delay[15:8], delay[7:0] (big-endian delay in ticks).
  - A packet holds floor(len/3) records. Trailing 1-2 bytes are ignored.
  - len=0 or len<3 gives zero records; the packet is re-armed immediately.
- IDLE:
  - Start rising edge -> rec_count<=0, go to WAIT_DATA.
  - Abort in IDLE has no effect.
- WAIT_DATA: on synced hasdata=1 -> latch len, ptr<=0.
  - Then go to FETCH if len>=3, else go to ARM.
- FETCH (3 byte reads):
  - Drive buf_out_addr=ptr, ptr+1, ptr+2.
  - Capture buf_out_q 2 cycles after each address.
  - Total 7 clk from the first address to holding the full record.
- DELAY: the tick counter counts PRESCALE clocks per tick.
  - delay=0 -> apply on the next clk.
  - delay=D -> apply exactly D*PRESCALE+1 clk after the record is captured.
- APPLY: line_out<=state; rec_count<=rec_count+1; ptr<=ptr+3.
  - If ptr+6 <= len, go to FETCH; else go to ARM.
  - Comparisons are 11-bit so ptr+6 cannot overflow.
- ARM: pulse buf_out_arm for 1 clk.
  - Hold in ARM_WAIT until buf_out_arm_ack=1, then go to WAIT_DATA.
  - line_out holds its last applied value between packets.
- Abort (rising edge, request 8'h03) in any non-IDLE state:
  - line_out<=IDLE_STATE within 1 clk of the detected edge; the pending record is discarded.
  - If a packet is held (state past WAIT_DATA and before the arm is acked), go through ARM/ARM_WAIT to release it, then go to IDLE.
  - Otherwise go to IDLE directly.
  - rec_count is kept.
- Start while busy: ignored.
- Start and abort requests cannot coincide, since there is one request code per strobe.
- Reset mid-operation: all outputs return to their reset values immediately. No arm is issued; the endpoint is re-armed only by host re-enumeration or by the next packet flow.
- busy is registered and equals (state != IDLE).

Test Plan:
- Single record: PRESCALE=1, start, packet len=3 bytes {8'h55,8'h00,8'h0A} -> line_out=8'h55 exactly 11 clk after the third byte is captured; rec_count=1; one buf_out_arm pulse; state WAIT_DATA.
- Back-to-back zero delay: len=6 {8'h01,0,0,8'h02,0,0} -> line_out goes 01 then 02, separated only by the fetch latency (8 clk); rec_count=2; a single arm after the second apply.
- Prescale and trailing bytes: PRESCALE=4, len=5 {8'hAA,8'h00,8'h03,x,x} -> 8'hAA applied 13 clk after capture; trailing bytes ignored; rec_count=1.
- Empty and short packets: len=0 and then len=2 -> no change on line_out, rec_count=0, one arm per packet.
- Abort during DELAY: record with delay 16'h1000 in progress, send abort -> line_out=IDLE_STATE next clk; one arm pulse; after ack, busy=0 and the record is never applied.
- Async reset mid-FETCH: assert reset -> line_out=IDLE_STATE, busy=0, rec_count=0, buf_out_arm=0 in the same cycle; after release, start and a new packet replay correctly.
